uart_tx_ctrl: RTL and testbench

UART transmit controller that owns its baud-rate timing.

- Holds a runtime-programmable baud divisor and generates a bit-period tick from the system clock.
- Sequences 8N1 frames (start, 8 data bits LSB-first, stop) onto the serial line.
- Accepts bytes from the pipeline's store/MMIO path over a valid/ready handshake and reports busy status for polling.

---
 rtl/uart_tx_ctrl.sv | 116 +++++++++++
 tb/tb_uart_tx_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// UART 8N1 transmit controller with a runtime-programmable baud divisor.
// Bytes enter over valid/ready; tx_o is a registered, glitch-free line.
module uart_tx_ctrl #(
  parameter int CLOCK_SYS    = 100_000_000,
  parameter int BAUD_DEFAULT = 115200,
  parameter int DIV_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_val,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             tx_o,
  output logic             busy
);

  localparam logic [DIV_W-1:0] DIV_RST =
    DIV_W'(CLOCK_SYS / BAUD_DEFAULT);
  localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       idx_q, idx_d;
  logic             tx_q, tx_d;
  logic             tick;
  logic             accept;

  assign tx_ready = (state_q == IDLE);
  assign busy     = ~tx_ready;
  assign tx_o     = tx_q;
  assign accept   = tx_valid & tx_ready;
  assign tick     = (cnt_q == div_q - DIV_W'(1));

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = tick ? '0 : cnt_q + DIV_W'(1);
    shift_d = shift_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        // the accepted frame already sees the newly loaded divisor
        if (div_load) begin
          div_d = (div_val < DIV_MIN) ? DIV_MIN : div_val;
        end
        if (accept) begin
          shift_d = tx_data;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          idx_d   = 3'd0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            tx_d = shift_q[1];
          end
        end
      end
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      div_q   <= DIV_RST;
      cnt_q   <= '0;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: per-cycle line model built from frame
// bit lists, plus directed frame measurements with literal values.
module tb_uart_tx_ctrl;

  localparam int DW = 16;
  localparam int DIV_RST = 100_000_000 / 115200;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          div_load = 1'b0;
  logic [DW-1:0] div_val = '0;
  logic [7:0]    tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic          tx_o;
  logic          busy;

  uart_tx_ctrl #(
    .CLOCK_SYS   (100_000_000),
    .BAUD_DEFAULT(115200),
    .DIV_W       (DW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .div_load(div_load),
    .div_val (div_val),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_o    (tx_o),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
  endtask

  // Reference model: the line is a queue of per-clock levels.
  logic    mq[$];
  logic    m_busy = 1'b0;
  logic    exp_tx = 1'b1;
  int      m_div = DIV_RST;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_busy <= 1'b0;
      m_div  <= DIV_RST;
      exp_tx <= 1'b1;
    end else begin
      int d;
      logic [9:0] fr;
      d = m_div;
      if (!m_busy) begin
        if (div_load) begin
          d = (int'(div_val) < 2) ? 2 : int'(div_val);
          m_div <= d;
        end
        if (tx_valid) begin
          fr = {1'b1, tx_data, 1'b0};
          for (int b = 0; b < 10; b++)
            repeat (d) mq.push_back(fr[b]);
        end
      end
      if (mq.size() > 0) begin
        exp_tx <= mq.pop_front();
        m_busy <= 1'b1;
      end else begin
        exp_tx <= 1'b1;
        m_busy <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      chk("line", tx_o, exp_tx);
      chk("ready", tx_ready, !m_busy);
      chk("busy", busy, m_busy);
    end
  end

  logic cap[$];

  // One frame; tx_data scrambled while busy, optional load while busy.
  task automatic frame(input logic [7:0] b, input logic dl,
                       input logic [DW-1:0] dv, input logic bl,
                       input logic [DW-1:0] bv);
    logic done;
    done = 1'b0;
    @(negedge clk);
    tx_data = b; tx_valid = 1'b1;
    div_load = dl; div_val = dv;
    @(posedge clk);
    cap.delete();
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      tx_valid = 1'b0;
      tx_data = 8'($urandom);
      if (tx_ready) begin
        div_load = 1'b0;
        done = 1'b1;
        break;
      end
      div_load = bl; div_val = bv;
      cap.push_back(tx_o);
    end
    if (!done) chk("frame_timeout", 0, 1);
  endtask

  function automatic logic [7:0] decode(input int d);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = cap[d * (i + 1) + d / 2];
    return r;
  endfunction

  logic exp5a[10] = '{0, 0, 1, 0, 1, 1, 0, 1, 0, 1};

  initial begin
    int zeros, low, idles;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx_o, 1);
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    @(negedge clk); reset = 1'b1;

    frame(8'h00, 1'b0, '0, 1'b0, '0);
    chk("rstdiv_len", cap.size(), 8680);
    zeros = 0;
    foreach (cap[i]) if (cap[i] == 1'b0) zeros++;
    chk("rstdiv_low", zeros, 7812);

    frame(8'h5A, 1'b1, 16'd4, 1'b0, '0);
    chk("5a_len", cap.size(), 40);
    for (int b = 0; b < 10; b++)
      chk($sformatf("5a_bit%0d", b), cap[4 * b + 2], exp5a[b]);

    // back-to-back with tx_valid held high
    @(negedge clk);
    tx_data = 8'hFF; tx_valid = 1'b1;
    @(posedge clk);
    cap.delete(); low = 0; idles = 0;
    for (int i = 0; i < 400 && idles < 2; i++) begin
      @(negedge clk);
      cap.push_back(tx_o);
      if (tx_ready) begin
        idles++;
        tx_data = 8'h00;
      end else begin
        low++;
        if (idles == 1) tx_valid = 1'b0;
      end
    end
    tx_valid = 1'b0;
    chk("b2b_low", low, 80);
    chk("b2b_len", cap.size(), 82);
    chk("b2b_stop", cap[36], 1);
    chk("b2b_idle", cap[40], 1);
    chk("b2b_start2", cap[41], 0);

    frame(8'hC3, 1'b0, '0, 1'b1, 16'd9);
    chk("busyload_len", cap.size(), 40);
    frame(8'h3C, 1'b0, '0, 1'b0, '0);
    chk("busyload_next", cap.size(), 40);

    frame(8'h81, 1'b1, 16'd0, 1'b0, '0);
    chk("clamp_len", cap.size(), 20);
    chk("clamp_start", cap[1], 0);
    chk("clamp_b0", cap[2], 1);
    chk("clamp_byte", decode(2), 8'h81);

    frame(8'hE7, 1'b1, 16'd6, 1'b0, '0);
    chk("div6_len", cap.size(), 60);
    chk("div6_byte", decode(6), 8'hE7);

    // reset in the middle of data bit 3
    frame(8'h11, 1'b1, 16'd4, 1'b0, '0);
    @(negedge clk);
    tx_data = 8'hA5; tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); tx_valid = 1'b0;
    repeat (16) @(negedge clk);
    chk("mid_bit3", tx_o, 0);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_tx", tx_o, 1);
    chk("mid_rst_ready", tx_ready, 1);
    chk("mid_rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    frame(8'h3C, 1'b0, '0, 1'b0, '0);
    chk("post_rst_len", cap.size(), 8680);
    chk("post_rst_byte", decode(868), 8'h3C);

    for (int n = 0; n < 25; n++) begin
      frame(8'($urandom), 1'($urandom),
            DW'($urandom_range(0, 7)), ($urandom % 4) == 0,
            DW'($urandom_range(8, 15)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
